// File: rtl/key_stream.sv
// Round-key stream: latches a set of NUM_ROUNDS subkeys and serves them one per
// valid/ready transfer, round 1 first. Define KEY_STREAM_DBUF_EN for a holding register.
module key_stream #(
    parameter int NUM_ROUNDS = 16,
    parameter int KEY_W      = 48
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_ROUNDS*KEY_W-1:0] round_keys_i,
    input  logic                        keys_valid_i,
    output logic                        keys_ready_o,
    input  logic                        flush_i,
    output logic [KEY_W-1:0]            subkey_o,
    output logic                        subkey_valid_o,
    input  logic                        subkey_ready_i,
    output logic [3:0]                  round_idx_o,
    output logic                        subkey_last_o,
    output logic                        busy_o
);
    localparam int         BUS_W    = NUM_ROUNDS * KEY_W;
    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [BUS_W-1:0] bank_q, bank_d;
    logic [3:0]       idx_q, idx_d;
    logic             accept;
    logic             xfer;
    logic             final_xfer;
`ifdef KEY_STREAM_DBUF_EN
    logic [BUS_W-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
`endif

    assign subkey_valid_o = (state_q == STREAM);
    assign busy_o         = subkey_valid_o;
    assign subkey_o       = bank_q[BUS_W-1 -: KEY_W];
    assign round_idx_o    = idx_q;
    assign subkey_last_o  = subkey_valid_o && (idx_q == LAST_IDX);

    assign xfer       = subkey_valid_o && subkey_ready_i;
    assign final_xfer = xfer && (idx_q == LAST_IDX);

    // Ready depends only on registered state plus rst/flush, never on subkey_ready_i.
`ifdef KEY_STREAM_DBUF_EN
    assign keys_ready_o = !rst && !flush_i && !hold_full_q;
`else
    assign keys_ready_o = !rst && !flush_i && (state_q == IDLE);
`endif
    assign accept = keys_valid_i && keys_ready_o;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d = state_q;
        bank_d  = bank_q;
        idx_d   = idx_q;
`ifdef KEY_STREAM_DBUF_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`endif
        if (flush_i) begin
            state_d = IDLE;
            idx_d   = '0;
`ifdef KEY_STREAM_DBUF_EN
            hold_full_d = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        bank_d  = round_keys_i;
                        idx_d   = '0;
                        state_d = STREAM;
                    end
                end
                STREAM: begin
                    if (xfer && !final_xfer) begin
                        bank_d = bank_q << KEY_W;
                        idx_d  = idx_q + 4'd1;
                    end else if (final_xfer) begin
                        state_d = IDLE;
                        idx_d   = '0;
`ifdef KEY_STREAM_DBUF_EN
                        // Chain straight into the next set: held set first, else bypass.
                        if (hold_full_q) begin
                            state_d     = STREAM;
                            bank_d      = hold_q;
                            hold_full_d = 1'b0;
                        end else if (accept) begin
                            state_d = STREAM;
                            bank_d  = round_keys_i;
                        end
`endif
                    end
`ifdef KEY_STREAM_DBUF_EN
                    if (accept && !final_xfer) begin
                        hold_d      = round_keys_i;
                        hold_full_d = 1'b1;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the key bank is reset as well, so subkey_o reads 0 rather than stale key material.
            state_q <= IDLE;
            bank_q  <= '0;
            idx_q   <= '0;
`ifdef KEY_STREAM_DBUF_EN
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the same pre-edge values.
            state_q <= state_d;
            bank_q  <= bank_d;
            idx_q   <= idx_d;
`ifdef KEY_STREAM_DBUF_EN
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
`endif
        end
    end
endmodule

// File: tb/tb_key_stream.sv
// Scoreboard bench for key_stream: each accepted key set queues its expected subkeys,
// a monitor compares every presented subkey and the ready/valid/busy flags each cycle.
module tb_key_stream;
    localparam int NR = 16;
    localparam int KW = 48;
    localparam int BW = NR * KW;

    logic          clk            = 1'b0;
    logic          rst            = 1'b1;
    logic [BW-1:0] round_keys_i   = '0;
    logic          keys_valid_i   = 1'b0;
    logic          keys_ready_o;
    logic          flush_i        = 1'b0;
    logic [KW-1:0] subkey_o;
    logic          subkey_valid_o;
    logic          subkey_ready_i = 1'b0;
    logic [3:0]    round_idx_o;
    logic          subkey_last_o;
    logic          busy_o;

    key_stream #(.NUM_ROUNDS(NR), .KEY_W(KW)) dut (
        .clk            (clk),
        .rst            (rst),
        .round_keys_i   (round_keys_i),
        .keys_valid_i   (keys_valid_i),
        .keys_ready_o   (keys_ready_o),
        .flush_i        (flush_i),
        .subkey_o       (subkey_o),
        .subkey_valid_o (subkey_valid_o),
        .subkey_ready_i (subkey_ready_i),
        .round_idx_o    (round_idx_o),
        .subkey_last_o  (subkey_last_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [KW-1:0] key;
        logic [3:0]    idx;
        logic          last;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks      = 0;
    int   n_pass        = 0;
    int   cyc           = 0;
    bit   mon_en        = 1'b0;
    int   rdy_mode      = 0;
    int   pat_i         = 0;
    int   xfer_cnt      = 0;
    int   run_len       = 0;
    int   last_run      = 0;
    int   last_xfer_cyc = -1;
    int   accept_cyc    = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference: round k (0-based) is the k-th KW-bit field counted from the MSB end.
    task automatic push_set(input logic [BW-1:0] s);
        exp_t e;
        for (int k = 0; k < NR; k++) begin
            e.key  = s[BW-1-k*KW -: KW];
            e.idx  = 4'(k);
            e.last = (k == NR - 1);
            sb_q.push_back(e);
        end
    endtask

    function automatic logic [BW-1:0] count_set();
        logic [BW-1:0] s;
        s = '0;
        for (int k = 1; k <= NR; k++) s[BW-1-KW*(k-1) -: KW] = KW'(k);
        return s;
    endfunction

    function automatic logic [BW-1:0] fill_set(input logic [KW-1:0] v);
        logic [BW-1:0] s;
        for (int k = 0; k < NR; k++) s[k*KW +: KW] = v;
        return s;
    endfunction

    function automatic logic [BW-1:0] rand_set();
        logic [BW-1:0] s;
        logic [63:0]   r;
        for (int k = 0; k < NR; k++) begin
            r = {$urandom(), $urandom()};
            s[k*KW +: KW] = r[KW-1:0];
        end
        return s;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       subkey_ready_i = 1'b1;
            1: begin
                subkey_ready_i = (pat_i % 3 == 0);
                pat_i++;
            end
            default: subkey_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    // Stimulus side of the scoreboard: a handshake queues a whole set, flush/rst drop it.
    always @(negedge clk) begin
        #1;
        if (rst || flush_i) sb_q.delete();
        else if (keys_valid_i && keys_ready_o) begin
            push_set(round_keys_i);
            accept_cyc = cyc;
        end
    end

    // Monitor: outstanding subkeys imply STREAM; the head must be presented until taken.
    always @(negedge clk) begin
        logic exp_vld;
        logic exp_rdy;
        if (mon_en) begin
            exp_vld = (sb_q.size() != 0);
`ifdef KEY_STREAM_DBUF_EN
            exp_rdy = !rst && !flush_i && (sb_q.size() <= NR);
`else
            exp_rdy = !rst && !flush_i && (sb_q.size() == 0);
`endif
            check("keys_ready", 64'(keys_ready_o), 64'(exp_rdy));
            check("subkey_valid", 64'(subkey_valid_o), 64'(exp_vld));
            check("busy", 64'(busy_o), 64'(exp_vld));
            if (subkey_valid_o) run_len++;
            else begin
                if (run_len != 0) last_run = run_len;
                run_len = 0;
            end
            if (subkey_valid_o && exp_vld) begin
                check("subkey", 64'(subkey_o), 64'(sb_q[0].key));
                check("round_idx", 64'(round_idx_o), 64'(sb_q[0].idx));
                check("subkey_last", 64'(subkey_last_o), 64'(sb_q[0].last));
                if (subkey_ready_i && !rst && !flush_i) begin
                    if (sb_q[0].last) last_xfer_cyc = cyc;
                    void'(sb_q.pop_front());
                    xfer_cnt++;
                end
            end
        end
    end

    task automatic send_set(input logic [BW-1:0] s);
        bit got;
        got          = 1'b0;
        round_keys_i = s;
        keys_valid_i = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (keys_ready_o) got = 1'b1;
        end
        check("accept_in_time", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        keys_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && (sb_q.size() != 0 || subkey_valid_o); i++) @(negedge clk);
        check("drain", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input int n);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (subkey_valid_o && round_idx_o == 4'(n)) found = 1'b1;
        end
        check("reach_idx", 64'(found), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        @(posedge clk);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_subkey", 64'(subkey_o), 64'd0);
        check("rst_idx", 64'(round_idx_o), 64'd0);
        check("rst_last", 64'(subkey_last_o), 64'd0);
        @(posedge clk);
        #1;

        // Counting set, ready tied high: 16 back-to-back subkeys, last 16 cycles after accept.
        rdy_mode = 0;
        x0 = xfer_cnt;
        send_set(count_set());
        wait_drain();
        check("set1_xfers", 64'(xfer_cnt - x0), 64'd16);
        check("set1_latency", 64'(last_xfer_cyc - accept_cyc), 64'd16);
        check("set1_run", 64'(last_run), 64'd16);

        // Same set with ready pattern 1,0,0: stalls must not skip or repeat.
        rdy_mode = 1;
        x0 = xfer_cnt;
        send_set(count_set());
        wait_drain();
        check("set2_xfers", 64'(xfer_cnt - x0), 64'd16);

        // Second set presented while the first streams.
        rdy_mode = 0;
        x0 = xfer_cnt;
        send_set(rand_set());
        send_set(rand_set());
`ifndef KEY_STREAM_DBUF_EN
        check("set3_accept_gap", 64'(accept_cyc - last_xfer_cyc), 64'd1);
`endif
        wait_drain();
        check("set3_xfers", 64'(xfer_cnt - x0), 64'd32);

        // Flush while round 5 is presented.
        send_set(rand_set());
        wait_idx(4);
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_at_idx", 64'(round_idx_o), 64'd5);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        check("flush_valid", 64'(subkey_valid_o), 64'd0);
        check("flush_ready", 64'(keys_ready_o), 64'd1);
        check("flush_idx", 64'(round_idx_o), 64'd0);
        @(posedge clk);
        #1;
        x0 = xfer_cnt;
        send_set(rand_set());
        wait_drain();
        check("post_flush_xfers", 64'(xfer_cnt - x0), 64'd16);

        // Reset while round 9 is presented.
        send_set(rand_set());
        wait_idx(8);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_at_idx", 64'(round_idx_o), 64'd9);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_subkey", 64'(subkey_o), 64'd0);
        check("midrst_idx", 64'(round_idx_o), 64'd0);
        check("midrst_valid", 64'(subkey_valid_o), 64'd0);
        check("midrst_last", 64'(subkey_last_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_ready", 64'(keys_ready_o), 64'd1);
        @(posedge clk);
        #1;

`ifdef KEY_STREAM_DBUF_EN
        // A then B queued in the holding register: 32 valid cycles with no gap.
        send_set(fill_set(48'hAAAAAAAAAAAA));
        send_set(fill_set(48'h555555555555));
        wait_drain();
        check("dbuf_hold_run", 64'(last_run), 64'd32);

        // B arrives exactly on A's final transfer: bypass into the bank.
        send_set(fill_set(48'hAAAAAAAAAAAA));
        wait_idx(14);
        @(posedge clk);
        #1;
        round_keys_i = fill_set(48'h555555555555);
        keys_valid_i = 1'b1;
        @(negedge clk);
        check("bypass_idx", 64'(round_idx_o), 64'd15);
        @(posedge clk);
        #1;
        keys_valid_i = 1'b0;
        check("bypass_same_cycle", 64'(accept_cyc - last_xfer_cyc), 64'd0);
        wait_drain();
        check("dbuf_bypass_run", 64'(last_run), 64'd32);
`endif

        // Random sets, random ready, occasional flush.
        rdy_mode = 2;
        for (int n = 0; n < 12; n++) begin
            send_set(rand_set());
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 20)) @(posedge clk);
                #1;
                flush_i = 1'b1;
                @(posedge clk);
                #1;
                flush_i = 1'b0;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/key_stream.md
Name: key_stream

Overview:
- Consumer end of the 768-bit round-key bus produced by the key generator.
- Latches one complete set of 16 x 48-bit round keys on a valid/ready handshake.
- Serves the keys one per transfer, round 1 first, to the iterative Feistel round datapath over a valid/ready stream with round index and last flag.
- Lets the round engine run one round per cycle without holding the full key bus.

Parameters:
- NUM_ROUNDS, 16, subkeys per set; supported range 2..16.
- KEY_W, 48, subkey width; bus width is NUM_ROUNDS*KEY_W (768 at defaults).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- round_keys_i  input  NUM_ROUNDS*KEY_W  key set; round k (1-based) at bits [NUM_ROUNDS*KEY_W-1-KEY_W*(k-1) -: KEY_W]
- keys_valid_i  input  1  round_keys_i valid
- keys_ready_o  output  1  block can accept a key set this cycle
- flush_i  input  1  abort current stream and discard all held keys
- subkey_o  output  KEY_W  current subkey
- subkey_valid_o  output  1  subkey_o / round_idx_o / subkey_last_o valid
- subkey_ready_i  input  1  round datapath consumes subkey this cycle
- round_idx_o  output  4  0-based round number of subkey_o
- subkey_last_o  output  1  high with the final subkey (round_idx_o == NUM_ROUNDS-1)
- busy_o  output  1  high while in STREAM

Behaviour:
- Priority: rst > flush_i > handshakes.
- Reset: state IDLE; bank, hold, subkey_o, round_idx_o all 0; subkey_valid_o, subkey_last_o, busy_o 0. keys_ready_o is 0 during the reset cycle and 1 from the first cycle after.
- Key accept: accept = keys_valid_i & keys_ready_o.
- Transfer: xfer = subkey_valid_o & subkey_ready_i.
- keys_ready_o has no combinational path from subkey_ready_i. It is forced 0 while flush_i is high.
- States:
  - IDLE: keys_ready_o = 1.
    - On accept: bank <= round_keys_i, idx <= 0, go to STREAM.
    - subkey_valid_o is high the next cycle (1-cycle latency).
  - STREAM:
    - subkey_valid_o = 1, subkey_o = bank[MSB -: KEY_W], round_idx_o = idx, subkey_last_o = (idx == NUM_ROUNDS-1).
    - On xfer with idx < NUM_ROUNDS-1: bank shifts left by KEY_W, idx++.
    - On xfer with idx == NUM_ROUNDS-1: go to IDLE, subkey_valid_o drops next cycle.
    - Without xfer: all outputs hold stable. Valid must not drop while ready is low.
    - keys_ready_o = 0, unless the optional feature is enabled.
- Base back-to-back timing:
  - Last xfer in cycle M.
  - IDLE in M+1, where a set can be accepted.
  - First subkey of the next set in M+2 (one idle cycle between sets).
- flush_i in any state:
  - Next cycle is IDLE with subkey_valid_o = 0 and idx = 0.
  - hold_full is cleared.
  - A keys_valid_i in the same cycle is not accepted.
- rst mid-stream: same as flush, plus all outputs return to reset values. Remaining subkeys are lost.
- Wrap: idx never exceeds NUM_ROUNDS-1. bank contents after the final shift are don't-care but must not be presented as valid.
- Bit order is never reversed here. Encrypt/decrypt ordering is resolved upstream.

Optional Feature:
- Macro: KEY_STREAM_DBUF_EN
- Defined:
  - Adds a second NUM_ROUNDS*KEY_W holding register with a hold_full flag.
  - keys_ready_o = !hold_full in both states (still 0 during flush_i).
  - Accept in STREAM writes hold and sets hold_full.
  - On the final xfer with hold_full: bank <= hold, idx <= 0, hold_full cleared, stay in STREAM. The next set's round 0 is valid the next cycle, with zero bubble.
  - Accept in the same cycle as the final xfer with hold empty: bank <= round_keys_i directly (bypass), stay in STREAM, hold_full stays 0.
  - Accept in IDLE behaves as in the base design.
- Undefined:
  - No holding register.
  - keys_ready_o is high only in IDLE.
  - Base timing applies.

Test Plan:
- Reset, then key set with round k subkey = 48'h000000_00000k (k = 1..16) and subkey_ready_i tied 1 -> subkey_valid_o high cycles 1..16 after accept; round_idx_o 0..15; subkey_o 1..16; subkey_last_o only with 16; busy_o drops after.
- Same set, subkey_ready_i toggling 1,0,0,1,... -> no subkey skipped or repeated; outputs stable while ready is 0; exactly 16 transfers.
- keys_valid_i held high during STREAM (macro off) -> keys_ready_o = 0 until IDLE; second set accepted one cycle after final xfer; its round 0 appears two cycles after final xfer.
- flush_i asserted at round_idx_o = 5 -> next cycle subkey_valid_o = 0, keys_ready_o = 1; new set streams from round 0 correctly.
- rst asserted at round_idx_o = 9 -> all outputs 0 next cycle; keys_ready_o 1 the cycle after rst deasserts.
- Macro on, two sets A (all 48'hAAAAAAAAAAAA) and B (all 48'h555555555555) presented back-to-back with ready tied 1 -> 32 consecutive valid cycles with no gap, A then B. Also repeat with B arriving exactly on A's final xfer (bypass path) -> same 32-cycle result.
